// File: rtl/stack_sequencer_pkg.sv
// Shared types for the stack sequencer: op codes, FSM states, defaults.
package stack_sequencer_pkg;

    localparam int         FLAG_W_DEF   = 4;
    localparam logic [7:0] VEC_ADDR_DEF = 8'h00;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_RTI  = 3'd5,
        OP_INTR = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH,
        S_POP_RD,
        S_POP_CAP,
        S_RTI_R1,
        S_RTI_R2,
        S_RTI_R3,
        S_INT_I1,
        S_INT_I2,
        S_INT_I3,
        S_INT_I4
    } state_e;

    function automatic logic op_valid(logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    function automatic state_e first_state(op_e op);
        state_e s;
        s = S_IDLE;
        unique case (op)
            OP_PUSH, OP_CALL: s = S_PUSH;
            OP_POP, OP_RET:   s = S_POP_RD;
            OP_RTI:           s = S_RTI_R1;
            OP_INTR:          s = S_INT_I1;
            default:          s = S_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Data-memory port between the stack sequencer (master) and memory (slave).
interface stack_sequencer_if;

    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/stack_sequencer.sv
// Multi-cycle PUSH/POP/CALL/RET/RTI/interrupt-entry sequencer on the SP port.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter logic [7:0] VEC_ADDR = VEC_ADDR_DEF,
    parameter int         FLAG_W   = FLAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [7:0]        push_data,
    input  logic [7:0]        pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [7:0]        sp_in,
    stack_sequencer_if.master mem,
    output logic              dec_sp,
    output logic              inc_sp,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [7:0]        pop_data,
    output logic              pop_valid,
    output logic [7:0]        pc_out,
    output logic              pc_load,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flags_load
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        pc_q, pc_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    logic [7:0] sp_nxt;
    logic [7:0] flags_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && op_valid(op)) begin
                    op_d    = op_e'(op);
                    data_d  = push_data;
                    pc_d    = pc_in;
                    flags_d = flags_in;
                    state_d = first_state(op_e'(op));
                end
            end
            S_PUSH:    state_d = S_IDLE;
            S_POP_RD:  state_d = S_POP_CAP;
            S_POP_CAP: state_d = S_IDLE;
            S_RTI_R1:  state_d = S_RTI_R2;
            S_RTI_R2:  state_d = S_RTI_R3;
            S_RTI_R3:  state_d = S_IDLE;
            S_INT_I1:  state_d = S_INT_I2;
            S_INT_I2:  state_d = S_INT_I3;
            S_INT_I3:  state_d = S_INT_I4;
            S_INT_I4:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Pops pre-increment: the slot above the current SP holds the top.
    assign sp_nxt = sp_in + 8'd1;

    always_comb begin
        flags_ext = '0;
        flags_ext[FLAG_W-1:0] = flags_q;
    end

    always_comb begin
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_we    = 1'b0;
        mem.mem_re    = 1'b0;
        dec_sp        = 1'b0;
        inc_sp        = 1'b0;
        done          = 1'b0;
        pop_data      = '0;
        pop_valid     = 1'b0;
        pc_out        = '0;
        pc_load       = 1'b0;
        flags_out     = '0;
        flags_load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_PUSH: begin
                mem.mem_addr  = sp_in;
                mem.mem_wdata = (op_q == OP_CALL) ? pc_q : data_q;
                mem.mem_we    = 1'b1;
                dec_sp        = 1'b1;
                done          = 1'b1;
            end
            S_POP_RD, S_RTI_R1: begin
                mem.mem_addr = sp_nxt;
                mem.mem_re   = 1'b1;
                inc_sp       = 1'b1;
            end
            S_POP_CAP: begin
                done = 1'b1;
                if (op_q == OP_RET) begin
                    pc_out  = mem.mem_rdata;
                    pc_load = 1'b1;
                end else begin
                    pop_data  = mem.mem_rdata;
                    pop_valid = 1'b1;
                end
            end
            S_RTI_R2: begin
                flags_out    = mem.mem_rdata[FLAG_W-1:0];
                flags_load   = 1'b1;
                mem.mem_addr = sp_nxt;
                mem.mem_re   = 1'b1;
                inc_sp       = 1'b1;
            end
            S_RTI_R3, S_INT_I4: begin
                pc_out  = mem.mem_rdata;
                pc_load = 1'b1;
                done    = 1'b1;
            end
            S_INT_I1: begin
                mem.mem_addr  = sp_in;
                mem.mem_wdata = pc_q;
                mem.mem_we    = 1'b1;
                dec_sp        = 1'b1;
            end
            S_INT_I2: begin
                mem.mem_addr  = sp_in;
                mem.mem_wdata = flags_ext;
                mem.mem_we    = 1'b1;
                dec_sp        = 1'b1;
            end
            S_INT_I3: begin
                mem.mem_addr = VEC_ADDR;
                mem.mem_re   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign stall = busy | (start & op_valid(op));

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench: per-cycle expected output records queued at stimulus time.
module tb_stack_sequencer;
    import stack_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] push_data = '0;
    logic [7:0] pc_in = '0;
    logic [3:0] flags_in = '0;
    logic [7:0] sp;

    logic       dec_sp, inc_sp, busy, stall, done;
    logic [7:0] pop_data, pc_out;
    logic       pop_valid, pc_load, flags_load;
    logic [3:0] flags_out;

    stack_sequencer_if mif ();

    stack_sequencer #(.VEC_ADDR(8'h00), .FLAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .push_data  (push_data),
        .pc_in      (pc_in),
        .flags_in   (flags_in),
        .sp_in      (sp),
        .mem        (mif.master),
        .dec_sp     (dec_sp),
        .inc_sp     (inc_sp),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .pc_out     (pc_out),
        .pc_load    (pc_load),
        .flags_out  (flags_out),
        .flags_load (flags_load)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy, stall, we, re, dec, inc, done, pv, pl, fl;
        logic [7:0] addr, wdata, pop, pc;
        logic [3:0] flags;
    } exp_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] init_byte(logic [7:0] a);
        return (a == 8'h00) ? 8'h40 : (a ^ 8'h3C);
    endfunction

    // Memory and R3 model, both driven only by the DUT's strobes.
    logic [7:0] mem [256];
    logic       tb_init = 1'b1;
    logic       sp_ld = 1'b0;
    logic [7:0] sp_ld_val = '0;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(8'(i));
            sp <= 8'h80;
            mif.mem_rdata <= '0;
        end else begin
            if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
            if (mif.mem_re) mif.mem_rdata <= mem[mif.mem_addr];
            if (sp_ld) sp <= sp_ld_val;
            else if (dec_sp) sp <= sp - 8'd1;
            else if (inc_sp) sp <= sp + 8'd1;
        end
    end

    logic [7:0] ref_mem [256];
    logic [7:0] ref_sp;
    exp_t       q[$];
    logic       mon_en = 1'b0;

    function automatic exp_t idle_r(logic stall_v);
        exp_t r;
        r = '0;
        r.stall = stall_v;
        return r;
    endfunction

    function automatic exp_t seq_r();
        exp_t r;
        r = '0;
        r.busy = 1'b1;
        r.stall = 1'b1;
        return r;
    endfunction

    function automatic exp_t obs();
        exp_t r;
        r.busy  = busy;
        r.stall = stall;
        r.we    = mif.mem_we;
        r.re    = mif.mem_re;
        r.dec   = dec_sp;
        r.inc   = inc_sp;
        r.done  = done;
        r.pv    = pop_valid;
        r.pl    = pc_load;
        r.fl    = flags_load;
        r.addr  = mif.mem_addr;
        r.wdata = mif.mem_wdata;
        r.pop   = pop_data;
        r.pc    = pc_out;
        r.flags = flags_out;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (q.size() > 0) e = q.pop_front();
            else e = idle_r(start && (op != 3'd0) && (op != 3'd7));
            check_eq("trace", 64'(obs()), 64'(e));
        end
    end

    task automatic set_sp(input logic [7:0] v);
        sp_ld = 1'b1;
        sp_ld_val = v;
        ref_sp = v;
        @(posedge clk); #1;
        sp_ld = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] d,
                         input logic [7:0] p, input logic [3:0] f,
                         input bit hold);
        exp_t r;
        logic [7:0] s0, a1, a2;
        int n;
        s0 = ref_sp;
        a1 = s0 + 8'd1;
        a2 = s0 + 8'd2;
        n = 0;
        q.push_back(idle_r((o != 3'd0) && (o != 3'd7)));
        case (o)
            3'd1, 3'd3: begin
                r = seq_r(); r.we = 1; r.addr = s0; r.dec = 1; r.done = 1;
                r.wdata = (o == 3'd1) ? d : p;
                q.push_back(r);
                ref_mem[s0] = r.wdata;
                ref_sp = s0 - 8'd1;
                n = 1;
            end
            3'd2, 3'd4: begin
                r = seq_r(); r.re = 1; r.addr = a1; r.inc = 1;
                q.push_back(r);
                r = seq_r(); r.done = 1;
                if (o == 3'd2) begin r.pv = 1; r.pop = ref_mem[a1]; end
                else begin r.pl = 1; r.pc = ref_mem[a1]; end
                q.push_back(r);
                ref_sp = a1;
                n = 2;
            end
            3'd5: begin
                r = seq_r(); r.re = 1; r.addr = a1; r.inc = 1;
                q.push_back(r);
                r = seq_r(); r.fl = 1; r.flags = ref_mem[a1][3:0];
                r.re = 1; r.addr = a2; r.inc = 1;
                q.push_back(r);
                r = seq_r(); r.pl = 1; r.pc = ref_mem[a2]; r.done = 1;
                q.push_back(r);
                ref_sp = a2;
                n = 3;
            end
            3'd6: begin
                r = seq_r(); r.we = 1; r.addr = s0; r.wdata = p; r.dec = 1;
                q.push_back(r);
                ref_mem[s0] = p;
                r = seq_r(); r.we = 1; r.addr = s0 - 8'd1;
                r.wdata = {4'h0, f}; r.dec = 1;
                q.push_back(r);
                ref_mem[s0 - 8'd1] = {4'h0, f};
                r = seq_r(); r.re = 1; r.addr = 8'h00;
                q.push_back(r);
                r = seq_r(); r.pl = 1; r.pc = ref_mem[8'h00]; r.done = 1;
                q.push_back(r);
                ref_sp = s0 - 8'd2;
                n = 4;
            end
            default: n = 0;
        endcase
        start = 1'b1;
        op = o;
        push_data = d;
        pc_in = p;
        flags_in = f;
        @(posedge clk); #1;
        if (hold) op = 3'd1;
        else start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1);
    end

    initial begin
        exp_t r;
        logic [7:0] s0;
        logic [2:0] ro;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(8'(i));
        ref_sp = 8'h80;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 64'(obs()), 64'(idle_r(1'b0)));
        tb_init = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;

        do_op(3'd1, 8'h5A, 8'h00, 4'h0, 0);
        check_eq("push_sp", 64'(sp), 64'(8'h7F));
        check_eq("push_mem", 64'(mem[8'h80]), 64'(8'h5A));
        do_op(3'd2, 8'h00, 8'h00, 4'h0, 0);
        check_eq("pop_sp", 64'(sp), 64'(8'h80));

        do_op(3'd3, 8'h00, 8'h77, 4'h0, 0);
        do_op(3'd4, 8'h00, 8'h00, 4'h0, 0);

        set_sp(8'hFF);
        do_op(3'd6, 8'h00, 8'h23, 4'hA, 0);
        check_eq("intr_pc_slot", 64'(mem[8'hFF]), 64'(8'h23));
        check_eq("intr_fl_slot", 64'(mem[8'hFE]), 64'(8'h0A));
        check_eq("intr_sp", 64'(sp), 64'(8'hFD));
        do_op(3'd5, 8'h00, 8'h00, 4'h0, 0);
        check_eq("rti_sp", 64'(sp), 64'(8'hFF));

        set_sp(8'h00);
        do_op(3'd1, 8'hC3, 8'h00, 4'h0, 0);
        check_eq("wrap_push_sp", 64'(sp), 64'(8'hFF));
        check_eq("wrap_push_mem", 64'(mem[8'h00]), 64'(8'hC3));
        do_op(3'd2, 8'h00, 8'h00, 4'h0, 0);
        check_eq("wrap_pop_sp", 64'(sp), 64'(8'h00));

        do_op(3'd0, 8'h11, 8'h22, 4'h3, 0);
        do_op(3'd7, 8'h11, 8'h22, 4'h3, 0);
        check_eq("ignored_sp", 64'(sp), 64'(8'h00));

        do_op(3'd2, 8'h00, 8'h00, 4'h0, 1);
        check_eq("busy_start_sp", 64'(sp), 64'(8'h01));

        // Reset lands in INTR cycle 2: only the PC slot write survives.
        s0 = ref_sp;
        q.push_back(idle_r(1'b1));
        r = seq_r(); r.we = 1; r.addr = s0; r.wdata = 8'h99; r.dec = 1;
        q.push_back(r);
        start = 1'b1; op = 3'd6; pc_in = 8'h99; flags_in = 4'h5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", 64'(obs()), 64'(idle_r(1'b0)));
        ref_mem[s0] = 8'h99;
        ref_sp = s0 - 8'd1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_sp", 64'(sp), 64'(8'h00));

        set_sp(8'h80);
        do_op(3'd6, 8'h00, 8'h5E, 4'h3, 0);
        do_op(3'd5, 8'h00, 8'h00, 4'h0, 0);

        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(1, 4));
            do_op(ro, 8'($urandom), 8'($urandom), 4'($urandom), 0);
        end
        repeat (2) @(posedge clk);
        #1;

        check_eq("sb_drain", 64'(q.size()), 64'd0);
        check_eq("final_sp", 64'(sp), 64'(ref_sp));
        for (int i = 0; i < 256; i++)
            check_eq($sformatf("mem_%02h", i), 64'(mem[i]), 64'(ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Multi-cycle controller on the initiating side of the register file's stack-pointer interface.
- Sequences PUSH, POP, CALL, RET, RTI and interrupt entry:
  - drives data-memory accesses at the R3 (SP) address;
  - issues dec_sp/inc_sp strobes to the register file;
  - returns popped data, PC and flags to the pipeline.
- Sits beside the MEM stage; stalls the pipeline while a sequence is in flight.

Parameters:
- VEC_ADDR, 8'h00, data-memory address holding the interrupt vector.
- FLAG_W, 4, width of the CCR/flags field saved on interrupt.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 RTI, 6 INTR, 7 reserved
- push_data  in  8  register value for PUSH
- pc_in  in  8  return PC for CALL/INTR
- flags_in  in  FLAG_W  flags for INTR
- sp_in  in  8  current R3 value from register file read port
- mem_rdata  in  8  memory read data, valid the cycle after mem_re
- mem_addr  out  8  memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- dec_sp  out  1  SP-- strobe to register file
- inc_sp  out  1  SP++ strobe to register file
- busy  out  1  high whenever state != IDLE
- stall  out  1  busy | (start & op valid), combinational
- done  out  1  one-cycle pulse in the final cycle of a sequence
- pop_data  out  8  popped value (POP)
- pop_valid  out  1  one-cycle pulse with pop_data
- pc_out  out  8  PC for redirect (RET, RTI, INTR vector)
- pc_load  out  1  one-cycle pulse with pc_out
- flags_out  out  FLAG_W  restored flags (RTI)
- flags_load  out  1  one-cycle pulse with flags_out

Behaviour:
- Reset (async, rst_n low):
  - state IDLE;
  - all strobes, done, busy, pop_valid, pc_load, flags_load low;
  - pop_data, pc_out, flags_out, the op latch and all operand latches 0.
- Reset mid-sequence: abort immediately; no further strobes; no partial completion pulses after release.
- Start:
  - In IDLE, start with op 1..6 latches op, push_data, pc_in and flags_in; the first sequence state begins next cycle.
  - op 0/7 are ignored and stay IDLE.
  - start while busy is ignored; the pipeline holds the request via stall.
- Stack convention: PUSH writes M[SP] then SP-- (post-decrement); POP does SP++ then reads M[SP+1] (pre-increment).
- SP sourcing: SP is always taken from sp_in. The register file updates R3 on the same edge that ends a strobe cycle, so sp_in is current in every state.
- Strobe rules: dec_sp and inc_sp are never high together; neither is high in IDLE.
- Address arithmetic: 8-bit modulo. SP=8'h00 PUSH writes 8'h00 and SP becomes 8'hFF. SP=8'hFF POP reads 8'h00.
- Sequence states (outputs decoded from state; "cycle n" = n cycles after the start cycle):
  - PUSH (cycle 1): mem_addr=sp_in, mem_wdata=push_data, mem_we, dec_sp, done → IDLE.
  - CALL (cycle 1): as PUSH with mem_wdata=pc_in, done → IDLE.
  - POP_RD (cycle 1): mem_addr=sp_in+1, mem_re, inc_sp → POP_CAP.
  - POP_CAP (cycle 2):
    - POP: pop_data=mem_rdata, pop_valid.
    - RET: pc_out=mem_rdata, pc_load.
    - done → IDLE.
  - RTI:
    - R1: mem_addr=sp_in+1, mem_re, inc_sp.
    - R2: flags_out=mem_rdata[FLAG_W-1:0], flags_load, plus mem_addr=sp_in+1, mem_re, inc_sp.
    - R3: pc_out=mem_rdata, pc_load, done.
    - Latency 3.
  - INTR:
    - I1: write pc_in at sp_in, dec_sp.
    - I2: write zero-extended flags at sp_in, dec_sp.
    - I3: mem_addr=VEC_ADDR, mem_re.
    - I4: pc_out=mem_rdata, pc_load, done.
    - Latency 4.
- Latencies (start to done): PUSH/CALL 1, POP/RET 2, RTI 3, INTR 4.
- Stack order: INTR pushes PC first and flags last, so RTI pops flags first and PC second; the round trip is exact.
- Back-to-back: a new start may be sampled in the cycle after done, i.e. in IDLE. There are no idle bubbles beyond that.

Decomposition:
- Shared package holds:
  - op encodings (OP_NOP..OP_INTR);
  - state enumeration;
  - FLAG_W default;
  - VEC_ADDR default.
- One FSM with an output decoder in a single module; no sub-module is natural.

Test Plan:
- PUSH, sp_in=8'h80, push_data=8'h5A → cycle 1: mem_we, addr 8'h80, wdata 8'h5A, dec_sp, done; R3 becomes 8'h7F.
- POP after that push, sp_in=8'h7F → cycle 1: inc_sp, mem_re, addr 8'h80; cycle 2: pop_data=8'h5A, pop_valid, done.
- INTR, sp_in=8'hFF, pc_in=8'h23, flags_in=4'hA, M[00]=8'h40:
  - M[FF]=8'h23, M[FE]=8'h0A;
  - two dec_sp pulses, R3 becomes 8'hFD;
  - pc_out=8'h40 with pc_load in cycle 4.
- RTI, sp_in=8'hFD → reads FE then FF; flags_out=4'hA in cycle 2; pc_out=8'h23 in cycle 3; R3 ends at 8'hFF.
- Wrap: PUSH at sp_in=8'h00 writes addr 00, R3 becomes FF. POP at sp_in=8'hFF reads addr 00. start asserted while busy is ignored (no extra strobes).
- rst_n low during INTR cycle 2 → all outputs 0 immediately; state IDLE; no pc_load after release.
